// File: rtl/apb2wb_pkg.sv
// Shared types and constants for the APB-to-Wishbone bridge.
package apb2wb_pkg;

  localparam int unsigned DW          = 32;
  localparam int unsigned SW          = 4;
  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RESP = 2'd2
  } state_e;

  // Registered Wishbone request payload (address kept apart, it is AW wide)
  typedef struct packed {
    logic [DW-1:0] dat;
    logic [SW-1:0] sel;
    logic          we;
  } wb_req_t;

endpackage

// File: rtl/apb2wb_bridge.sv
// APB slave to Wishbone classic master bridge, one outstanding transfer.
// Optional wait-cycle watchdog enabled by defining APB2WB_TIMEOUT_EN.
module apb2wb_bridge
  import apb2wb_pkg::*;
#(
  parameter int unsigned AW      = 12,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_psel,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [AW-1:0] i_paddr,
  input  logic [31:0]   i_pwdata,
  input  logic [3:0]    i_pstrb,
  output logic [31:0]   o_prdata,
  output logic          o_pready,
  output logic          o_pslverr,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic          i_wb_err
);

  state_e        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  wb_req_t       req_q, req_d;
  logic          cyc_q, cyc_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic [DW-1:0] prdata_q, prdata_d;
  logic          setup_c, skip_c, resp_c, timeout_c;

  assign setup_c = i_psel & ~i_penable;
  assign skip_c  = i_pwrite & (i_pstrb == SW'(0));
  assign resp_c  = i_wb_ack | i_wb_err;

`ifdef APB2WB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_c = (cnt_q == CW'(TIMEOUT - 1));

  // Counts WB cycles spent waiting; cleared whenever WB is left
  always_comb begin
    cnt_d = '0;
    if (state_q == WB && state_d == WB) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      req_q     <= '0;
      cyc_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      req_q     <= req_d;
      cyc_q     <= cyc_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Next state and next register values
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    req_d     = req_q;
    cyc_d     = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;

    unique case (state_q)
      IDLE: begin
        if (setup_c) begin
          adr_d     = i_paddr;
          req_d.dat = i_pwdata;
          req_d.we  = i_pwrite;
          req_d.sel = i_pwrite ? i_pstrb : 4'hF;
          if (skip_c) begin
            state_d  = RESP;
            prdata_d = '0;
          end else begin
            state_d = WB;
            cyc_d   = 1'b1;
          end
        end
      end

      WB: begin
        if (!i_psel) begin
          state_d = IDLE;
        end else if (resp_c) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = i_wb_err;
          prdata_d  = req_q.we ? '0 : i_wb_rdt;
        end else if (timeout_c) begin
          state_d   = RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = TIMEOUT_RDATA;
        end else begin
          cyc_d = 1'b1;
        end
      end

      RESP: begin
        // A skipped write arrives with pready low; raise it once so the
        // APB transfer still takes setup plus two access cycles.
        if (pready_q) state_d  = IDLE;
        else          pready_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_prdata  = prdata_q;
  assign o_pready  = pready_q;
  assign o_pslverr = pslverr_q;
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = req_q.dat;
  assign o_wb_sel  = req_q.sel;
  assign o_wb_we   = req_q.we;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = cyc_q;

endmodule

// File: doc/apb2wb_bridge.md
APB2WB_BRIDGE -- requirements
Module: apb2wb_bridge

Interface
REQ-001 SHALL have parameter AW, default 12, APB/Wishbone byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, Wishbone wait-cycle limit (used only with APB2WB_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports i_psel, i_penable, i_pwrite  in  1 each  APB select, enable and write.
REQ-006 SHALL have port i_paddr  in  AW  APB byte address.
REQ-007 SHALL have ports i_pwdata  in  32  write data, and i_pstrb  in  4  write byte strobes.
REQ-008 SHALL have ports o_prdata  out  32, o_pready  out  1, o_pslverr  out  1  APB response.
REQ-009 SHALL have ports o_wb_adr  out  AW, o_wb_dat  out  32, o_wb_sel  out  4, o_wb_we  out  1, o_wb_cyc  out  1, o_wb_stb  out  1  Wishbone master request.
REQ-010 SHALL have ports i_wb_rdt  in  32, i_wb_ack  in  1, i_wb_err  in  1  Wishbone response.

Function
REQ-011 SHALL implement FSM IDLE -> WB -> RESP -> IDLE.
REQ-012 In IDLE, APB setup phase (i_psel=1, i_penable=0) SHALL register i_paddr, i_pwdata, i_pwrite and sel, then enter WB next cycle.
REQ-013 sel SHALL be i_pstrb on writes and 4'hF on reads.
REQ-014 A write with i_pstrb=0 SHALL skip WB, go directly to RESP, issue no Wishbone cycle and report o_pslverr=0.
REQ-015 In WB, o_wb_cyc and o_wb_stb SHALL be 1, with o_wb_adr, o_wb_dat, o_wb_sel and o_wb_we driven from the registered values.
REQ-016 i_wb_ack or i_wb_err SHALL be accepted in any WB cycle, including the first.
REQ-017 On acceptance, the FSM SHALL drop o_wb_cyc/o_wb_stb next cycle and enter RESP.
REQ-018 On acceptance, o_prdata SHALL capture i_wb_rdt for reads and 0 for writes.
REQ-019 On acceptance, the pslverr register SHALL capture i_wb_err.
REQ-020 If i_wb_ack and i_wb_err are asserted together, err SHALL win.
REQ-021 In RESP, o_pready SHALL be 1 for exactly one cycle, o_pslverr SHALL be valid, and the FSM SHALL then return to IDLE.
REQ-022 o_pready SHALL be 0 in IDLE and WB; o_pslverr SHALL be 0 outside RESP.
REQ-023 Minimum APB transfer SHALL be 3 cycles (setup + 2 access), given ack in the first WB cycle.
REQ-024 If i_psel falls while in WB (APB violation), the bridge SHALL drop o_wb_cyc/o_wb_stb next cycle and return to IDLE without asserting o_pready.
REQ-025 o_prdata SHALL hold its value outside RESP.
REQ-026 A new setup phase SHALL NOT be accepted before the FSM is back in IDLE.

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE.
REQ-028 While rst_n=0, o_wb_cyc, o_wb_stb, o_wb_we, o_pready and o_pslverr SHALL be 0.
REQ-029 While rst_n=0, o_wb_adr, o_wb_dat, o_wb_sel and o_prdata SHALL be 0, and the timeout counter SHALL be 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transfer immediately and asynchronously.

Configuration
REQ-031 With APB2WB_TIMEOUT_EN defined, the bridge SHALL count WB cycles from 0.
REQ-032 With APB2WB_TIMEOUT_EN defined, after TIMEOUT cycles without ack/err the bridge SHALL drop the Wishbone cycle, enter RESP with o_pslverr=1 and o_prdata=32'hDEAD_BEEF, and clear the counter.
REQ-033 Without APB2WB_TIMEOUT_EN, no counter SHALL exist and WB SHALL wait indefinitely.

Structure
REQ-034 A shared package apb2wb_pkg SHALL hold the FSM state typedef (IDLE/WB/RESP), the default TIMEOUT, and the timeout read-data constant 32'hDEAD_BEEF.
REQ-035 The block SHALL be a single module; no sub-module is natural.

Verification
REQ-036 Read at 0x010 with ack in the first WB cycle, i_wb_rdt=0x0000_00A5 -> o_wb_adr=0x010, o_wb_sel=4'hF, o_pready on setup+2, o_prdata=0x0000_00A5, o_pslverr=0.
REQ-037 Write 0x55 to 0x00C with i_pstrb=4'b0001 and ack after 3 wait cycles -> o_wb_we=1, o_wb_sel=4'b0001, o_wb_dat=0x55, cyc/stb held 4 cycles, o_pready one cycle later.
REQ-038 Write with i_pstrb=0 -> o_wb_cyc never asserted, o_pready on setup+2, o_pslverr=0.
REQ-039 i_wb_err together with i_wb_ack on a read -> o_pslverr=1 in the RESP cycle.
REQ-040 With APB2WB_TIMEOUT_EN and TIMEOUT=8, no ack -> cyc dropped after 8 WB cycles, o_pslverr=1, o_prdata=32'hDEAD_BEEF.
REQ-041 rst_n low in the 2nd WB cycle -> o_wb_cyc=0 immediately; after release, the next transfer completes normally.
